// File: rtl/excess3_to_bin_pkg.sv
// Shared constants and types for the serial excess-3 decoder.
package excess3_pkg;

    // Excess-3 bias and the legal code window (decimal 0..9 after de-biasing)
    localparam logic [3:0] XS3_BIAS = 4'd3;
    localparam logic [3:0] XS3_MIN  = 4'b0011;
    localparam logic [3:0] XS3_MAX  = 4'b1100;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // True when an excess-3 code maps onto a decimal digit
    function automatic logic xs3_code_ok(input logic [3:0] code);
        return (code >= XS3_MIN) && (code <= XS3_MAX);
    endfunction

endpackage

// File: rtl/excess3_to_bin_if.sv
// Digit-in / word-out handshake bundle for the excess-3 decoder.
interface excess3_to_bin_if
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    bcd_digit_t            in_digit;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_bin;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_err;

    // Driver of digits and consumer of results
    modport master (
        output in_valid, in_digit, out_ready,
        input  in_ready, out_valid, out_bin, out_bcd, out_err
    );

    // The decoder itself
    modport slave (
        input  in_valid, in_digit, out_ready,
        output in_ready, out_valid, out_bin, out_bcd, out_err
    );
endinterface

// File: rtl/excess3_to_bin_digit_dec.sv
// Single-digit excess-3 decode: strips the bias and flags illegal codes.
module excess3_digit_dec
    import excess3_pkg::*;
(
    input  logic [3:0] code,
    output bcd_digit_t digit,
    output logic       valid
);

    // Illegal codes decode to zero so they add nothing to the accumulator
    always_comb begin
        valid = xs3_code_ok(code);
        digit = valid ? bcd_digit_t'(code - XS3_BIAS) : bcd_digit_t'(0);
    end

endmodule

// File: rtl/excess3_to_bin.sv
// Serial excess-3 word decoder: collects DIGITS codes MSD first, builds
// packed BCD and binary in parallel, and presents one registered result
// per word over a valid/ready handshake.
module excess3_to_bin
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
)(
    input  logic             clk,
    input  logic             rst,
    excess3_to_bin_if.slave  bus
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_e            state;
    logic [CNT_W-1:0]  count;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_next;
    logic              err;
    logic              err_next;
    bcd_digit_t        dig;
    logic              dig_ok;
    logic              accept;
    logic              last;

    excess3_digit_dec u_dec (
        .code  (bus.in_digit),
        .digit (dig),
        .valid (dig_ok)
    );

    // Ready only while collecting; held low for the whole of reset
    assign bus.in_ready = (state == COLLECT) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = (count == CNT_W'(DIGITS - 1));

    // Next word state if the current digit is accepted (acc*10 + d)
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + OUT_W'(dig);
        bcd_next = (bcd << 4) | BCD_W'(dig);
        err_next = err | ~dig_ok;
    end

    // Collect/hold sequencer with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            count         <= '0;
            acc           <= '0;
            bcd           <= '0;
            err           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_bin   <= '0;
            bus.out_bcd   <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        acc <= acc_next;
                        bcd <= bcd_next;
                        err <= err_next;
                        if (last) begin
                            // Word complete: publish, zeroing data when any code was bad
                            state         <= HOLD;
                            count         <= '0;
                            bus.out_valid <= 1'b1;
                            bus.out_err   <= err_next;
                            bus.out_bin   <= err_next ? '0 : acc_next;
                            bus.out_bcd   <= err_next ? '0 : bcd_next;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= COLLECT;
                        count         <= '0;
                        acc           <= '0;
                        bcd           <= '0;
                        err           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.out_bin   <= '0;
                        bus.out_bcd   <= '0;
                        bus.out_err   <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_excess3_to_bin.sv
// Directed bench for excess3_to_bin: a 4-digit instance for most vectors
// and a 2-digit instance for the parameter variant.
module tb_excess3_to_bin;
    import excess3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    excess3_to_bin_if #(.DIGITS(4), .OUT_W(14)) bus  ();
    excess3_to_bin_if #(.DIGITS(2), .OUT_W(7))  bus2 ();

    excess3_to_bin #(.DIGITS(4), .OUT_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    excess3_to_bin #(.DIGITS(2), .OUT_W(7)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One digit into the 4-digit instance after 'gap' idle cycles
    task automatic send(input logic [3:0] code, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_digit = code;
        chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_digit = 4'hF;
    endtask

    task automatic send_word(input logic [15:0] codes, input int maxgap);
        for (int i = 0; i < 4; i++)
            send(codes[15-4*i -: 4], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_out(input string tag, input logic [13:0] bin,
                             input logic [15:0] bcd, input logic err);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_bin"},   32'(bus.out_bin),   32'(bin));
        chk({tag, "_bcd"},   32'(bus.out_bcd),   32'(bcd));
        chk({tag, "_err"},   32'(bus.out_err),   32'(err));
        chk({tag, "_inrdy"}, 32'(bus.in_ready),  32'd0);
    endtask

    // Result handshake, then in_ready must be back the very next cycle
    task automatic take(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_take_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_take_inrdy"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic send2(input logic [3:0] code);
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_digit = code;
        chk("v2_in_ready", 32'(bus2.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_digit   = 4'h0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_digit  = 4'h0;
        bus2.out_ready = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bin",   32'(bus.out_bin),   32'd0);
        chk("rst_out_bcd",   32'(bus.out_bcd),   32'd0);
        chk("rst_out_err",   32'(bus.out_err),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic word 1234, back to back
        send_word(16'b0100_0101_0110_0111, 0);
        check_out("basic", 14'd1234, 16'h1234, 1'b0);
        take("basic");

        // Largest and smallest values
        send_word(16'b1100_1100_1100_1100, 0);
        check_out("max", 14'h270F, 16'h9999, 1'b0);
        take("max");
        send_word(16'b0011_0011_0011_0011, 0);
        check_out("zero", 14'd0, 16'h0000, 1'b0);
        take("zero");

        // Invalid code in digit 1 zeroes the word; next word is clean
        send_word(16'b0100_0000_0101_0110, 0);
        check_out("bad", 14'd0, 16'h0000, 1'b1);
        take("bad");
        send_word(16'b0100_0100_0100_0100, 0);
        check_out("after_bad", 14'd1111, 16'h1111, 1'b0);
        take("after_bad");

        // Input gaps, then 5 cycles of backpressure with a stray digit offered
        send_word(16'b1000_0011_1010_1100, 3);
        check_out("gap", 14'd5079, 16'h5079, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_digit = 4'b0100;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_bin",   32'(bus.out_bin),   32'd5079);
            chk("bp_bcd",   32'(bus.out_bcd),   32'h5079);
            chk("bp_inrdy", 32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 1'b0;
        take("gap");

        // Reset mid-word discards the partial digits
        send(4'b0100, 0);
        send(4'b0101, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_inrdy", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_word(16'b0100_0101_0110_0111, 0);
        check_out("after_rst", 14'd1234, 16'h1234, 1'b0);

        // Asynchronous reset while holding a result clears it between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("holdrst_valid", 32'(bus.out_valid), 32'd0);
        chk("holdrst_bin",   32'(bus.out_bin),   32'd0);
        chk("holdrst_inrdy", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("holdrst_release_inrdy", 32'(bus.in_ready), 32'd1);

        // Two-digit instance: 98
        send2(4'b1100);
        send2(4'b1011);
        chk("v2_valid", 32'(bus2.out_valid), 32'd1);
        chk("v2_bin",   32'(bus2.out_bin),   32'd98);
        chk("v2_bcd",   32'(bus2.out_bcd),   32'h98);
        chk("v2_err",   32'(bus2.out_err),   32'd0);
        @(negedge clk);
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b0;
        chk("v2_take_valid", 32'(bus2.out_valid), 32'd0);
        chk("v2_take_inrdy", 32'(bus2.in_ready),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/excess3_to_bin.md
# excess3_to_bin

Serial excess-3 decoder: accepts a fixed-length word of excess-3 coded decimal digits, most significant digit first, one digit per handshake. It removes the +3 bias per digit, checks each code for validity, and accumulates the word into both packed BCD and a binary value. It sits on the receive side of the digit path, undoing the BCD-to-excess-3 encoding applied upstream, and hands one result per word downstream over a valid/ready interface.

## Interface
- DIGITS, 4: digits per word, 1..8.
- OUT_W, 14: binary result width; must satisfy 2^OUT_W > 10^DIGITS - 1 (14 for 4 digits).
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_digit holds a digit.
- in_ready  output  1  block accepts a digit this cycle.
- in_digit  input  4  excess-3 code.
- out_valid  output  1  result word available.
- out_ready  input  1  downstream accepts the result.
- out_bin  output  OUT_W  binary value of the word.
- out_bcd  output  4*DIGITS  packed BCD; first digit received in the top nibble.
- out_err  output  1  at least one digit in the word was an invalid code.

## Operation
- States: COLLECT, HOLD.
- COLLECT: in_ready=1. On in_valid&in_ready:
  - d = in_digit - 3.
  - Valid codes are 4'b0011..4'b1100. Codes 0000–0010 and 1101–1111 set the sticky error flag, and the digit is taken as d=0.
  - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d in OUT_W bits. No overflow is possible under the OUT_W rule.
  - bcd <= {bcd[4*DIGITS-5:0], d}.
  - Digit count increments.
- When the DIGITS-th digit is accepted, the next state is HOLD.
- HOLD: in_ready=0.
  - out_valid=1, out_bin=acc, out_bcd=bcd, out_err=err.
  - If err is set, out_bin and out_bcd are forced to 0.
  - On out_ready: return to COLLECT, clearing acc, bcd, err and the count.
- in_valid low in COLLECT: no state change. Gaps between digits of any length are allowed.
- in_digit is ignored when it is not accepted.

## Timing
- Reset (asynchronous, effective immediately):
  - state=COLLECT; count, acc, bcd, err cleared.
  - out_valid=0, out_bin=0, out_bcd=0, out_err=0.
  - in_ready is forced to 0 while rst is high and goes to 1 in the first cycle after release.
- Reset mid-word discards all partial digits. The next accepted digit is digit 0 of a new word.
- Latency: out_valid rises in the cycle after the clock edge that accepts the last digit.
- out_valid, out_bin, out_bcd and out_err are registered. They hold stable while out_valid=1 and out_ready=0.
- A digit and a result are never transferred in the same cycle, because in_ready and out_valid are mutually exclusive.
- in_ready returns to 1 in the cycle after the out handshake.
- Maximum throughput: one word per DIGITS+1 cycles.
- out_ready while out_valid=0 is ignored.
- in_ready does not depend combinationally on out_ready.

## Structure
- Package excess3_pkg holds:
  - XS3_BIAS=4'd3, XS3_MIN=4'b0011, XS3_MAX=4'b1100;
  - state encoding COLLECT/HOLD;
  - the BCD digit type.
- Sub-module excess3_digit_dec: combinational; 4-bit code in, 4-bit BCD digit and a valid bit out. Instantiated once in the datapath.
- The count register width is clog2(DIGITS+1).

## Test plan
- Basic word: codes 0100, 0101, 0110, 0111 back-to-back -> out_valid one cycle later; out_bin=1234, out_bcd=16'h1234, out_err=0.
- Maximum value: four codes 1100 -> out_bin=9999 (14'h270F), out_bcd=16'h9999. Four codes 0011 -> out_bin=0, out_err=0.
- Invalid digit: codes 0100, 0000, 0101, 0110 -> out_err=1, out_bin=0, out_bcd=0. The next word 0100, 0100, 0100, 0100 -> out_bin=1111, out_err=0.
- Backpressure and gaps:
  - Random 0–3 cycle in_valid gaps on input, word 5, 0, 7, 9 (codes 1000, 0011, 1010, 1100).
  - out_ready held low for 5 cycles -> out_bin=5079 stable, in_ready=0 throughout.
  - in_ready=1 in the cycle after out_ready=1.
- Reset mid-word: accept two digits, assert rst asynchronously between edges -> out_valid=0 immediately. After release, word 1, 2, 3, 4 -> out_bin=1234.
- Parameter variant DIGITS=2, OUT_W=7: codes 1100, 1011 -> out_bin=98, out_bcd=8'h98.
